// File: rtl/zeta_table_gen.sv
// Builds the NTT twiddle table: writes ZETA^i mod Q to address bitrev(i), three cycles per entry.
// Define ZGEN_MONT_EN to write entries in Montgomery form (seeded with 2^32 mod Q).
module zeta_table_gen #(
  parameter int unsigned WIDTH  = 23,
  parameter int unsigned LENGTH = 256,
  parameter int unsigned Q      = 8380417,
  parameter int unsigned ZETA   = 1753,
  localparam int unsigned AW    = $clog2(LENGTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned MW = WIDTH + 2;

`ifdef ZGEN_MONT_EN
  localparam logic [WIDTH-1:0] ACC0 = WIDTH'((64'd1 << 32) % 64'(Q));
`else
  localparam logic [WIDTH-1:0] ACC0 = WIDTH'(1);
`endif

  localparam logic [MW-1:0]    M_BAR  = MW'((128'd1 << PW) / 128'(Q));
  localparam logic [PW+MW-1:0] Q_W    = (PW+MW)'(Q);
  localparam logic [WIDTH+1:0] Q_R    = (WIDTH+2)'(Q);
  localparam logic [PW-1:0]    ZETA_P = PW'(ZETA);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_MUL, S_RED, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    i_q, i_d, addr_q, addr_d;
  logic [WIDTH-1:0] acc_q, acc_d, data_q, data_d;
  logic [PW-1:0]    prod_q, prod_d;

  logic [PW+MW-1:0] bar_prod, bar_sub;
  logic [MW-1:0]    q_est;
  logic [WIDTH+1:0] red_r0, red_r1, red_r2;
  logic [WIDTH-1:0] red_out;
  logic             unused_bits;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] x);
    logic [AW-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < AW; b++) r[b] = x[AW-1-b];
    return r;
  endfunction

  // Barrett with k = 2*WIDTH: the quotient estimate is at most 2 low, so two conditional subtracts suffice.
  always_comb begin
    bar_prod = {{MW{1'b0}}, prod_q} * {{PW{1'b0}}, M_BAR};
    q_est    = bar_prod[PW+MW-1:PW];
    bar_sub  = {{MW{1'b0}}, prod_q} - ({{PW{1'b0}}, q_est} * Q_W);
    red_r0   = bar_sub[WIDTH+1:0];
    red_r1   = (red_r0 >= Q_R) ? red_r0 - Q_R : red_r0;
    red_r2   = (red_r1 >= Q_R) ? red_r1 - Q_R : red_r1;
    red_out  = red_r2[WIDTH-1:0];
  end

  assign unused_bits = ^{bar_prod[PW-1:0], bar_sub[PW+MW-1:WIDTH+2], red_r2[WIDTH+1:WIDTH]};

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    addr_d  = addr_q;
    data_d  = data_q;
    busy    = 1'b0;
    done    = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WRITE;
          i_d     = '0;
          acc_d   = ACC0;
          addr_d  = bitrev('0);
          data_d  = ACC0;
        end
      end
      S_WRITE: begin
        wr_en   = 1'b1;
        busy    = 1'b1;
        state_d = (i_q == AW'(LENGTH - 1)) ? S_DONE : S_MUL;
      end
      S_MUL: begin
        busy    = 1'b1;
        prod_d  = {{WIDTH{1'b0}}, acc_q} * ZETA_P;
        state_d = S_RED;
      end
      S_RED: begin
        busy    = 1'b1;
        acc_d   = red_out;
        i_d     = i_q + AW'(1);
        addr_d  = bitrev(i_q + AW'(1));
        data_d  = red_out;
        state_d = S_WRITE;
      end
      S_DONE: begin
        done    = 1'b1;
        i_d     = '0;
        acc_d   = ACC0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      acc_q   <= ACC0;
      prod_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign wr_addr = addr_q;
  assign wr_data = data_q;

endmodule
